hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: none; `TUSE_NONE` = 2'd3 and the select encodings come from the shared package.
REQ-002 SHALL have `clk  input  1`: single rising-edge clock.
REQ-003 SHALL have `reset  input  1`: asynchronous, active-high reset.
REQ-004 SHALL have `D_rs  input  5` and `D_rt  input  5`: source register addresses of the instruction in D.
REQ-005 SHALL have `D_tuse_rs  input  2` and `D_tuse_rt  input  2`: cycles from D until each operand is consumed; 3 means not read.
REQ-006 SHALL have `D_dst  input  5`: destination register of the instruction in D; 0 means no write.
REQ-007 SHALL have `D_tnew  input  2`: cycles after entering E until the result exists (0 = lui/jal, 1 = ALU, 2 = load).
REQ-008 SHALL have `stall  output  1`: hold PC and the D register, and insert a bubble into E.
REQ-009 SHALL have `sel_D_rs  output  2` and `sel_D_rt  output  2`: 0 = register file, 1 = E forward, 2 = M forward.
REQ-010 SHALL have `sel_E_alu1  output  2` and `sel_E_alu2  output  2`: 0 = E register value, 1 = M forward, 2 = W forward.
REQ-011 SHALL have `sel_M_wd  output  1`: 0 = M register rt value, 1 = W forward.

Function
REQ-012 SHALL hold internal tracking slots:
- E slot: {rs, rt, dst, tnew}
- M slot: {rt, dst, tnew}
- W slot: {dst}
REQ-013 SHALL advance the slots on every clock edge:
- W.dst <= M.dst
- M <= {E.rt, E.dst, E.tnew saturating-decrement}
- E <= {D_rs, D_rt, D_dst, D_tnew} when stall = 0
REQ-014 SHALL load the E slot with a bubble (all fields 0) when stall = 1; D inputs are then re-presented unchanged by the pipeline.
REQ-015 SHALL define a match as producer dst equal to the consumer address, with the address nonzero; register 0 never matches.
REQ-016 SHALL compute stall combinationally, per operand whose tuse is not 3, as the OR of:
- E match with E.tnew > tuse
- M match with (M.tnew) > tuse
REQ-017 SHALL set `sel_D_rs` (same rule for rt):
- 1 if E match and E.tnew = 0
- else 2 if M match and M.tnew = 0
- else 0
REQ-018 SHALL set `sel_E_alu1` using E.rs (same rule for `sel_E_alu2` using E.rt):
- 1 if M match and M.tnew = 0
- else 2 if W match
- else 0
REQ-019 SHALL set `sel_M_wd` to 1 when M.rt matches W.dst, else 0.
REQ-020 SHALL give the nearest producing stage priority when several stages match.
REQ-021 SHALL never assert a forward select toward a stage whose tnew is greater than 0.
REQ-022 SHALL have zero latency from slot contents and D inputs to all outputs; slot updates are visible the cycle after the edge.
REQ-023 SHALL clear a stall on its own after at most 2 cycles, because tnew decrements every cycle.

Reset
REQ-024 SHALL clear all slots to 0 asynchronously when `reset` = 1, independent of `clk`.
REQ-025 SHALL therefore hold stall = 0 and all selects = 0 while reset is asserted.
REQ-026 SHALL discard any in-progress stall when reset is asserted mid-stall; after release, tracking starts from empty slots.

Structure
REQ-027 SHALL take the following from the shared pipeline package:
- select encodings: `FWD_RF`, `FWD_E`, `FWD_M`, `FWD_W`
- `TUSE_NONE`
- tnew class constants
- the slot record typedef
REQ-028 SHALL instantiate one sub-module, `hazard_match`, which evaluates a single operand against one producer slot and returns {match, ready, must_stall}; it is reused for every operand/stage pair.
REQ-029 SHALL keep the slot registers in the top level, with no other state.

Verification
REQ-030 SHALL cover a load-use hazard:
- lw $8 (dst = 8, tnew = 2), then add with rs = 8, tuse = 1
- required: stall = 1 for exactly 1 cycle
- required: next cycle, sel_E_alu1 = 2 (W forward)
REQ-031 SHALL cover ALU-to-ALU forwarding:
- add dst = 9, tnew = 1, then sub with rt = 9, tuse = 1
- required: no stall
- required: next cycle, sel_E_alu2 = 1 (M forward)
REQ-032 SHALL cover an ALU result feeding a branch:
- add dst = 10, then beq with rs = 10, tuse = 0
- required: stall = 1 for 1 cycle
- required: then sel_D_rs = 2 (M forward)
REQ-033 SHALL cover register 0:
- producer dst = 0, consumer rs = 0
- required: stall = 0 and all selects = 0 throughout
REQ-034 SHALL cover store-data forwarding:
- lw dst = 4, then sw with rt = 4, tuse = 2
- required: no stall
- required: sel_M_wd = 1 when the sw is in M
REQ-035 SHALL cover reset during a stall:
- assert reset while stall = 1
- required: stall drops to 0 immediately, without waiting for a clock edge
- required: after release, no spurious forward selects

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared pipeline constants and slot records for hazard tracking.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a; stall is the only flow-control signal in this pipeline.
package hazard_ctrl_pkg;

    // Operand consumption time meaning "this operand is never read".
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // tnew classes: cycles after entering E until the result exists.
    localparam logic [1:0] TNEW_LUI  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // D-stage operand selects.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    // E-stage operand selects: 0 keeps the E register value, 1 takes M, 2 takes W.
    localparam logic [1:0] FWD_E_FROM_M = 2'd1;
    localparam logic [1:0] FWD_W        = 2'd2;

    // Producer/consumer record for the instruction in E.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
    } slot_t;

    // M only still consumes rt (store data), so rs is dropped there.
    typedef struct packed {
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
    } m_slot_t;

    // tnew counts down once per stage and never wraps below zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        return (tnew == TNEW_LUI) ? TNEW_LUI : tnew - 2'd1;
    endfunction

    // True when a result class is still outstanding at all.
    function automatic logic tnew_pending(input logic [1:0] tnew);
        return (tnew == TNEW_ALU) || (tnew == TNEW_LOAD);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Purpose: compare one consumer operand against one producer slot.
// Latency: purely combinational, zero cycles.
// Backpressure: none; must_stall is an input to the top-level stall OR.
import hazard_ctrl_pkg::*;

module hazard_match (
    input  logic [4:0] src,
    input  logic [1:0] tuse,
    input  logic [4:0] prod_dst,
    input  logic [1:0] prod_tnew,
    output logic       match,
    output logic       ready,
    output logic       must_stall
);

    // Register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        match      = (src != 5'd0) && (src == prod_dst);
        ready      = match && !tnew_pending(prod_tnew);
        must_stall = match && (tuse != TUSE_NONE) && (prod_tnew > tuse);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: stall and forwarding control for the 5-stage pipeline (D/E/M/W tracking).
// Latency: outputs are combinational from slot state and D inputs; slots update on each edge.
// Backpressure: stall holds PC/D and injects a bubble into E; it self-clears within 2 cycles.
import hazard_ctrl_pkg::*;

module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_dst,
    input  logic [1:0] D_tnew,
    output logic       stall,
    output logic [1:0] sel_D_rs,
    output logic [1:0] sel_D_rt,
    output logic [1:0] sel_E_alu1,
    output logic [1:0] sel_E_alu2,
    output logic       sel_M_wd
);

    // Operand/producer pairs evaluated by the shared comparator.
    localparam int P_DRS_E = 0;
    localparam int P_DRS_M = 1;
    localparam int P_DRT_E = 2;
    localparam int P_DRT_M = 3;
    localparam int P_ERS_M = 4;
    localparam int P_ERS_W = 5;
    localparam int P_ERT_M = 6;
    localparam int P_ERT_W = 7;
    localparam int P_MRT_W = 8;
    localparam int NPAIR   = 9;

    slot_t      e_q;
    m_slot_t    m_q;
    logic [4:0] w_dst_q;

    logic [4:0] pr_src   [NPAIR];
    logic [1:0] pr_tuse  [NPAIR];
    logic [4:0] pr_dst   [NPAIR];
    logic [1:0] pr_tnew  [NPAIR];
    logic [NPAIR-1:0] pr_match;
    logic [NPAIR-1:0] pr_ready;
    logic [NPAIR-1:0] pr_stall;

    // Advance the tracking slots; a stall turns the E entry into a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_dst_q <= '0;
        end else begin
            w_dst_q <= m_q.dst;
            m_q     <= '{rt: e_q.rt, dst: e_q.dst, tnew: tnew_dec(e_q.tnew)};
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q <= '{rs: D_rs, rt: D_rt, dst: D_dst, tnew: D_tnew};
            end
        end
    end

    // Route each consumer operand to the producer slot it is checked against.
    // E and M consumers read now, so their tuse is irrelevant and forced to "none".
    always_comb begin
        pr_src[P_DRS_E]  = D_rs;     pr_tuse[P_DRS_E] = D_tuse_rs;
        pr_dst[P_DRS_E]  = e_q.dst;  pr_tnew[P_DRS_E] = e_q.tnew;
        pr_src[P_DRS_M]  = D_rs;     pr_tuse[P_DRS_M] = D_tuse_rs;
        pr_dst[P_DRS_M]  = m_q.dst;  pr_tnew[P_DRS_M] = m_q.tnew;
        pr_src[P_DRT_E]  = D_rt;     pr_tuse[P_DRT_E] = D_tuse_rt;
        pr_dst[P_DRT_E]  = e_q.dst;  pr_tnew[P_DRT_E] = e_q.tnew;
        pr_src[P_DRT_M]  = D_rt;     pr_tuse[P_DRT_M] = D_tuse_rt;
        pr_dst[P_DRT_M]  = m_q.dst;  pr_tnew[P_DRT_M] = m_q.tnew;
        pr_src[P_ERS_M]  = e_q.rs;   pr_tuse[P_ERS_M] = TUSE_NONE;
        pr_dst[P_ERS_M]  = m_q.dst;  pr_tnew[P_ERS_M] = m_q.tnew;
        pr_src[P_ERS_W]  = e_q.rs;   pr_tuse[P_ERS_W] = TUSE_NONE;
        pr_dst[P_ERS_W]  = w_dst_q;  pr_tnew[P_ERS_W] = TNEW_LUI;
        pr_src[P_ERT_M]  = e_q.rt;   pr_tuse[P_ERT_M] = TUSE_NONE;
        pr_dst[P_ERT_M]  = m_q.dst;  pr_tnew[P_ERT_M] = m_q.tnew;
        pr_src[P_ERT_W]  = e_q.rt;   pr_tuse[P_ERT_W] = TUSE_NONE;
        pr_dst[P_ERT_W]  = w_dst_q;  pr_tnew[P_ERT_W] = TNEW_LUI;
        pr_src[P_MRT_W]  = m_q.rt;   pr_tuse[P_MRT_W] = TUSE_NONE;
        pr_dst[P_MRT_W]  = w_dst_q;  pr_tnew[P_MRT_W] = TNEW_LUI;
    end

    for (genvar g = 0; g < NPAIR; g++) begin : g_match
        hazard_match u_match (
            .src        (pr_src[g]),
            .tuse       (pr_tuse[g]),
            .prod_dst   (pr_dst[g]),
            .prod_tnew  (pr_tnew[g]),
            .match      (pr_match[g]),
            .ready      (pr_ready[g]),
            .must_stall (pr_stall[g])
        );
    end

    // Stall on any D operand needed before its producer delivers; selects
    // prefer the nearest stage and only ever point at a finished result.
    always_comb begin
        stall      = pr_stall[P_DRS_E] | pr_stall[P_DRS_M] |
                     pr_stall[P_DRT_E] | pr_stall[P_DRT_M];
        sel_D_rs   = pr_ready[P_DRS_E] ? FWD_E :
                     pr_ready[P_DRS_M] ? FWD_M : FWD_RF;
        sel_D_rt   = pr_ready[P_DRT_E] ? FWD_E :
                     pr_ready[P_DRT_M] ? FWD_M : FWD_RF;
        sel_E_alu1 = pr_ready[P_ERS_M] ? FWD_E_FROM_M :
                     pr_ready[P_ERS_W] ? FWD_W : FWD_RF;
        sel_E_alu2 = pr_ready[P_ERT_M] ? FWD_E_FROM_M :
                     pr_ready[P_ERT_W] ? FWD_W : FWD_RF;
        sel_M_wd   = pr_ready[P_MRT_W];
    end

    // Raw match bits and the E/M-consumer stall terms are not needed downstream.
    logic unused_pair_bits;
    assign unused_pair_bits = &{1'b0, pr_match, pr_stall[NPAIR-1:P_ERS_M]};

endmodule
